// File: rtl/vga_timing_gen.sv
// vga_timing_gen: parametrised VGA/VESA raster timing generator (pclk domain).
// Ports:
//   pclk, rst_n            clock, async active-low reset
//   en                     pixel enable; counters advance only when 1
//   hcount, vcount         raster position (CNT_W bits)
//   hblnk, vblnk           blanking flags
//   hsync, vsync           sync pulses, active level HSYNC_POL / VSYNC_POL
//   line_start             one-cycle strobe when hcount first shows 0
//   frame_start            one-cycle strobe when (hcount,vcount) first show (0,0)
//   frame_cnt              16-bit frame counter, present only with VGA_TIMING_FRAME_CNT_EN
// Optional feature macro: VGA_TIMING_FRAME_CNT_EN
module vga_timing_gen #(
    parameter int unsigned CNT_W     = 11,
    parameter int unsigned H_ACTIVE  = 800,
    parameter int unsigned H_FP      = 40,
    parameter int unsigned H_SYNC    = 128,
    parameter int unsigned H_BP      = 88,
    parameter int unsigned V_ACTIVE  = 600,
    parameter int unsigned V_FP      = 1,
    parameter int unsigned V_SYNC    = 4,
    parameter int unsigned V_BP      = 23,
    parameter bit          HSYNC_POL = 1'b1,
    parameter bit          VSYNC_POL = 1'b1
) (
    input  logic             pclk,
    input  logic             rst_n,
    input  logic             en,
    output logic [CNT_W-1:0] hcount,
    output logic [CNT_W-1:0] vcount,
    output logic             hblnk,
    output logic             vblnk,
    output logic             hsync,
    output logic             vsync,
    output logic             line_start,
    output logic             frame_start
`ifdef VGA_TIMING_FRAME_CNT_EN
    ,
    output logic [15:0]      frame_cnt
`endif
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam longint unsigned CNT_RANGE = 64'(1) << CNT_W;

    // Decode thresholds; all are below H_TOTAL/V_TOTAL so they fit in CNT_W bits.
    localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] H_BLNK   = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] V_BLNK   = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] HS_BEG   = CNT_W'(H_ACTIVE + H_FP);
    localparam logic [CNT_W-1:0] HS_END   = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CNT_W-1:0] VS_BEG   = CNT_W'(V_ACTIVE + V_FP);
    localparam logic [CNT_W-1:0] VS_END   = CNT_W'(V_ACTIVE + V_FP + V_SYNC);

    // Elaboration-time geometry sanity checks.
    if (64'(H_TOTAL) > CNT_RANGE || 64'(V_TOTAL) > CNT_RANGE) begin : g_bad_total
        $error("vga_timing_gen: H_TOTAL/V_TOTAL exceed counter range");
    end
    if (H_FP == 0 || H_SYNC == 0 || H_BP == 0 || V_FP == 0 || V_SYNC == 0 || V_BP == 0) begin : g_bad_porch
        $error("vga_timing_gen: porch/sync parameters must be non-zero");
    end

    logic [CNT_W-1:0] h_nxt_c;
    logic [CNT_W-1:0] v_nxt_c;
    logic             h_wrap_c;
    logic             f_wrap_c;

    // Next-state raster position; decodes below use it so flags align with the shown counts.
    always_comb begin
        h_nxt_c  = hcount;
        v_nxt_c  = vcount;
        h_wrap_c = 1'b0;
        f_wrap_c = 1'b0;
        if (en) begin
            h_wrap_c = (hcount == H_LAST);
            h_nxt_c  = h_wrap_c ? '0 : hcount + CNT_W'(1);
            if (h_wrap_c) begin
                f_wrap_c = (vcount == V_LAST);
                v_nxt_c  = f_wrap_c ? '0 : vcount + CNT_W'(1);
            end
        end
    end

    // Registered counters, flags and strobes.
    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            hcount      <= '0;
            vcount      <= '0;
            hblnk       <= 1'b0;
            vblnk       <= 1'b0;
            hsync       <= ~HSYNC_POL;
            vsync       <= ~VSYNC_POL;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            hcount      <= h_nxt_c;
            vcount      <= v_nxt_c;
            hblnk       <= (h_nxt_c >= H_BLNK);
            vblnk       <= (v_nxt_c >= V_BLNK);
            hsync       <= (h_nxt_c >= HS_BEG && h_nxt_c < HS_END) ? HSYNC_POL : ~HSYNC_POL;
            vsync       <= (v_nxt_c >= VS_BEG && v_nxt_c < VS_END) ? VSYNC_POL : ~VSYNC_POL;
            line_start  <= h_wrap_c;
            frame_start <= f_wrap_c;
        end
    end

`ifdef VGA_TIMING_FRAME_CNT_EN
    // Frame counter lands in the same cycle frame_start is shown.
    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            frame_cnt <= 16'd0;
        end else if (f_wrap_c) begin
            frame_cnt <= frame_cnt + 16'd1;
        end
    end
`endif

endmodule
